// File: rtl/conv_pkg.sv
// conv_pkg: shared widths and helpers for the 3x3 convolution slice.
//   DEF_PIX_WIDTH / DEF_COEF_WIDTH : default pixel and coefficient widths
//   prod_width() / acc_width()     : derived product and accumulator widths
//   saturate()                     : clamp a signed value to [0, 2^pw-1]
package conv_pkg;

    localparam int unsigned DEF_PIX_WIDTH  = 16;
    localparam int unsigned DEF_COEF_WIDTH = 8;

    // Unsigned pixel is zero-extended by one bit before the signed multiply.
    function automatic int unsigned prod_width(input int unsigned pw, input int unsigned cw);
        return pw + cw + 1;
    endfunction

    // Nine products summed: four guard bits make overflow impossible.
    function automatic int unsigned acc_width(input int unsigned pw, input int unsigned cw);
        return prod_width(pw, cw) + 4;
    endfunction

    function automatic logic [31:0] saturate(input logic signed [63:0] val,
                                             input int unsigned       pw);
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< pw) - 64'sd1;
        if (val < 64'sd0) begin
            return '0;
        end
        if (val > max_val) begin
            return max_val[31:0];
        end
        return val[31:0];
    endfunction

endpackage

// File: rtl/conv3x3_window_mac_mac9.sv
// conv_mac9: four-stage 3x3 multiply-accumulate pipeline with sideband.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/eol/eof   : window qualifier and end-of-row/frame markers
//   window             : 9 unsigned pixels, w[i*3+j] at [(i*3+j)*P +: P]
//   kernel             : 9 signed coefficients, same layout
//   pix_out            : saturated, shifted result (holds when not valid)
//   pix_valid/eol/eof  : result strobe and its markers
module conv_mac9 import conv_pkg::*; #(
    parameter int unsigned PIX_WIDTH  = DEF_PIX_WIDTH,
    parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_eol,
    input  logic                    in_eof,
    input  logic [9*PIX_WIDTH-1:0]  window,
    input  logic [9*COEF_WIDTH-1:0] kernel,
    output logic [PIX_WIDTH-1:0]    pix_out,
    output logic                    pix_valid,
    output logic                    pix_eol,
    output logic                    pix_eof
);

    localparam int unsigned PROD_W = prod_width(PIX_WIDTH, COEF_WIDTH);
    localparam int unsigned ACC_W  = acc_width(PIX_WIDTH, COEF_WIDTH);

    logic signed [PROD_W-1:0] prod [9];
    logic signed [ACC_W-1:0]  row_sum [3];
    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  shifted;
    // Sideband per stage: {valid, eol, eof}
    logic [2:0] s1_side, s2_side, s3_side;

    always_comb begin
        shifted = total >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 9; k++) begin
                prod[k] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                row_sum[i] <= '0;
            end
            total     <= '0;
            s1_side   <= '0;
            s2_side   <= '0;
            s3_side   <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < 9; k++) begin
                prod[k] <= PROD_W'($signed({1'b0, window[k*PIX_WIDTH +: PIX_WIDTH]}))
                         * PROD_W'($signed(kernel[k*COEF_WIDTH +: COEF_WIDTH]));
            end
            for (int unsigned i = 0; i < 3; i++) begin
                row_sum[i] <= ACC_W'(prod[3*i]) + ACC_W'(prod[3*i+1]) + ACC_W'(prod[3*i+2]);
            end
            total   <= row_sum[0] + row_sum[1] + row_sum[2];
            s1_side <= {in_valid, in_valid & in_eol, in_valid & in_eof};
            s2_side <= s1_side;
            s3_side <= s2_side;

            pix_valid <= s3_side[2];
            pix_eol   <= s3_side[1];
            pix_eof   <= s3_side[0];
            if (s3_side[2]) begin
                pix_out <= PIX_WIDTH'(saturate(64'(shifted), PIX_WIDTH));
            end
        end
    end

endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: sliding 3x3 window over a column stream plus MAC.
//   clk, rst_n  : clock, asynchronous active-low reset
//   col_valid   : col_in valid this cycle (no backpressure)
//   col_in      : {row r-2, row r-1, row r} pixels of one column
//   sof         : with col_valid, this column is (0,0) of a frame
//   kernel_in   : 9 signed coefficients, latched on sof
//   pix_out     : result pixel for centre (row-1, col-1)
//   pix_valid   : single-cycle result strobe, 4 cycles after acceptance
//   pix_eol     : last result of an output row
//   pix_eof     : last result of the frame
module conv3x3_window_mac import conv_pkg::*; #(
    parameter int unsigned PIX_WIDTH    = DEF_PIX_WIDTH,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned COEF_WIDTH   = DEF_COEF_WIDTH,
    parameter int unsigned SHIFT        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    col_valid,
    input  logic [3*PIX_WIDTH-1:0]  col_in,
    input  logic                    sof,
    input  logic [9*COEF_WIDTH-1:0] kernel_in,
    output logic [PIX_WIDTH-1:0]    pix_out,
    output logic                    pix_valid,
    output logic                    pix_eol,
    output logic                    pix_eof
);

    localparam int unsigned CW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    logic [CW-1:0]             col_cnt, cur_col;
    logic [RW-1:0]             row_cnt, cur_row;
    logic [3*PIX_WIDTH-1:0]    cols [3];    // cols[0] oldest
    logic [9*COEF_WIDTH-1:0]   kernel;
    logic [9*PIX_WIDTH-1:0]    window;
    logic                      win_valid, win_eol, win_eof;

    // Counters hold the position expected for the next column; sof overrides it.
    always_comb begin
        cur_col = sof ? '0 : col_cnt;
        cur_row = sof ? '0 : row_cnt;
    end

    // Window row i (0 = oldest row) sits in the upper slice of each column word.
    always_comb begin
        window = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                window[(i*3+j)*PIX_WIDTH +: PIX_WIDTH] = cols[j][(2-i)*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            for (int unsigned j = 0; j < 3; j++) begin
                cols[j] <= '0;
            end
            kernel    <= '0;
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
            if (col_valid) begin
                cols[0]   <= cols[1];
                cols[1]   <= cols[2];
                cols[2]   <= col_in;
                // Stale columns from the previous row are excluded by the col>=2 test.
                win_valid <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
                win_eol   <= (cur_col == COL_LAST);
                win_eof   <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
                if (cur_col == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                end else begin
                    col_cnt <= cur_col + CW'(1);
                    row_cnt <= cur_row;
                end
                if (sof) begin
                    kernel <= kernel_in;
                end
            end
        end
    end

    conv_mac9 #(
        .PIX_WIDTH (PIX_WIDTH),
        .COEF_WIDTH(COEF_WIDTH),
        .SHIFT     (SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (win_valid),
        .in_eol   (win_eol),
        .in_eof   (win_eof),
        .window   (window),
        .kernel   (kernel),
        .pix_out  (pix_out),
        .pix_valid(pix_valid),
        .pix_eol  (pix_eol),
        .pix_eof  (pix_eof)
    );

endmodule
